// File: rtl/seq_reorder_buf.sv
// seq_reorder_buf
// Tag-ordered reorder buffer. Up to NUM_WR tagged words per cycle are appended
// to a compacting buffer; a tag FIFO holds the order in which words must leave.
// Each cycle the oldest buffered word whose tag equals the FIFO head is moved
// into a registered output slot that honours downstream backpressure.
module seq_reorder_buf #(
    parameter int TAG_WIDTH   = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WR      = 4,
    parameter int BUFSIZE_POW = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_WR-1:0]            wr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wrdata_bi,
    input  logic [NUM_WR*TAG_WIDTH-1:0]  wrtag_bi,
    input  logic                         tag_fifo_wrreq,
    input  logic [TAG_WIDTH-1:0]         tag_fifo_wdata,
    output logic                         tag_fifo_full,
    input  logic                         rdy_i,
    output logic                         wr_o,
    output logic [DATA_WIDTH-1:0]        wrdata_bo,
    output logic                         wr_ready_o,
    output logic [BUFSIZE_POW:0]         cursize_o,
    output logic                         overflow_o
);

    localparam int DEPTH = 2 ** BUFSIZE_POW;
    localparam int IDX_W = BUFSIZE_POW;
    localparam int CNT_W = BUFSIZE_POW + 1;
    localparam int SUM_W = BUFSIZE_POW + 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_d  [DEPTH];
    logic [CNT_W-1:0]      cursize_q;
    logic [CNT_W-1:0]      cursize_d;
    logic                  overflow_q;
    logic                  overflow_d;

    logic                  wr_o_q;
    logic [DATA_WIDTH-1:0] wrdata_q;

    logic [TAG_WIDTH-1:0]  fifo_mem_q [DEPTH];
    logic [IDX_W-1:0]      fifo_rd_ptr_q;
    logic [IDX_W-1:0]      fifo_wr_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;

    // ------------------------------------------------------------------
    // Write port unpacking
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] wr_data_a [NUM_WR];
    logic [TAG_WIDTH-1:0]  wr_tag_a  [NUM_WR];

    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_unpack
            assign wr_data_a[gi] = wrdata_bi[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wr_tag_a[gi]  = wrtag_bi[gi*TAG_WIDTH +: TAG_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tag FIFO status and head
    // ------------------------------------------------------------------
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [TAG_WIDTH-1:0] fifo_head;
    logic                 fifo_push;

    assign fifo_full  = (fifo_cnt_q == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = fifo_mem_q[fifo_rd_ptr_q];

    // ------------------------------------------------------------------
    // Match search: per-entry hit, then lowest-index priority pick
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] hit;
    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             slot_free;
    logic             pop;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            // Only occupied entries may match; stale contents above cursize are ignored.
            assign hit[gi] = (CNT_W'(gi) < cursize_q) && (tag_q[gi] == fifo_head);
        end
    endgenerate

    // Lowest index wins so duplicate tags leave in arrival order.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!match_found && hit[i]) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    assign slot_free = !wr_o_q || rdy_i;
    assign pop       = slot_free && !fifo_empty && match_found;

    // A push into a full FIFO only lands when the same cycle frees a slot.
    assign fifo_push = tag_fifo_wrreq && (!fifo_full || pop);

    // ------------------------------------------------------------------
    // Shifted-down view of the buffer used when an entry is removed
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_up [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_up  [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi < DEPTH - 1) begin : g_mid
                assign data_up[gi] = data_q[gi+1];
                assign tag_up[gi]  = tag_q[gi+1];
            end else begin : g_top
                assign data_up[gi] = '0;
                assign tag_up[gi]  = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next buffer contents: compaction after pop, then in-order appends
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] app_cnt;

    // Compute compacted buffer, append accepted writes, flag dropped ones.
    always_comb begin
        data_d     = data_q;
        tag_d      = tag_q;
        overflow_d = overflow_q;
        app_cnt    = cursize_q - CNT_W'(pop);

        // Close the gap left by the popped entry.
        for (int i = 0; i < DEPTH; i++) begin
            if (pop && (IDX_W'(i) >= match_idx)) begin
                data_d[i] = data_up[i];
                tag_d[i]  = tag_up[i];
            end
        end

        // Lower ports claim positions first; once the buffer is full every
        // remaining strobe this cycle is dropped.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_i[p]) begin
                if (app_cnt == CNT_W'(DEPTH)) begin
                    overflow_d = 1'b1;
                end else begin
                    data_d[app_cnt[IDX_W-1:0]] = wr_data_a[p];
                    tag_d[app_cnt[IDX_W-1:0]]  = wr_tag_a[p];
                    app_cnt                    = app_cnt + CNT_W'(1);
                end
            end
        end

        cursize_d = app_cnt;
    end

    // Buffer registers; reset wipes every entry and the sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            cursize_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            tag_q      <= tag_d;
            cursize_q  <= cursize_d;
            overflow_q <= overflow_d;
        end
    end

    // Tag FIFO pointers and fill count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_rd_ptr_q <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr_q <= fifo_wr_ptr_q + IDX_W'(1);
            end
            if (pop) begin
                fifo_rd_ptr_q <= fifo_rd_ptr_q + IDX_W'(1);
            end
            case ({fifo_push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Tag FIFO storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && fifo_push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= tag_fifo_wdata;
        end
    end

    // Output slot: load on pop, hold under backpressure, otherwise clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_o_q   <= 1'b0;
            wrdata_q <= '0;
        end else if (pop) begin
            wr_o_q   <= 1'b1;
            wrdata_q <= data_q[match_idx];
        end else if (slot_free) begin
            wr_o_q   <= 1'b0;
            wrdata_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_o          = wr_o_q;
    assign wrdata_bo     = wrdata_q;
    assign cursize_o     = cursize_q;
    assign overflow_o    = overflow_q;
    assign tag_fifo_full = fifo_full;
    // Extra bit so cursize + NUM_WR cannot wrap before the compare.
    assign wr_ready_o    = (({1'b0, cursize_q} + SUM_W'(NUM_WR)) <= SUM_W'(DEPTH));

endmodule

// File: tb/tb_seq_reorder_buf.sv
// Directed bench for seq_reorder_buf: expected output words are queued as
// stimulus is driven and retired by a monitor whenever a word is accepted.
module tb_seq_reorder_buf;

    logic         clk;
    logic         rst_i;
    logic [3:0]   wr_i;
    logic [127:0] wrdata_bi;
    logic [7:0]   wrtag_bi;
    logic         tag_fifo_wrreq;
    logic [1:0]   tag_fifo_wdata;
    logic         tag_fifo_full;
    logic         rdy_i;
    logic         wr_o;
    logic [31:0]  wrdata_bo;
    logic         wr_ready_o;
    logic [3:0]   cursize_o;
    logic         overflow_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    seq_reorder_buf #(
        .TAG_WIDTH   (2),
        .DATA_WIDTH  (32),
        .NUM_WR      (4),
        .BUFSIZE_POW (3)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wr_i           (wr_i),
        .wrdata_bi      (wrdata_bi),
        .wrtag_bi       (wrtag_bi),
        .tag_fifo_wrreq (tag_fifo_wrreq),
        .tag_fifo_wdata (tag_fifo_wdata),
        .tag_fifo_full  (tag_fifo_full),
        .rdy_i          (rdy_i),
        .wr_o           (wr_o),
        .wrdata_bo      (wrdata_bo),
        .wr_ready_o     (wr_ready_o),
        .cursize_o      (cursize_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [1:0] t, input logic [31:0] d);
        wr_i[p]              = 1'b1;
        wrdata_bi[p*32 +: 32] = d;
        wrtag_bi[p*2 +: 2]    = t;
    endtask

    task automatic clr_wr();
        wr_i      = '0;
        wrdata_bi = '0;
        wrtag_bi  = '0;
    endtask

    task automatic push_tag(input logic [1:0] t);
        tag_fifo_wrreq = 1'b1;
        tag_fifo_wdata = t;
    endtask

    task automatic no_push();
        tag_fifo_wrreq = 1'b0;
        tag_fifo_wdata = '0;
    endtask

    // Scoreboard: every accepted output word must be the next expected one.
    always @(negedge clk) begin
        if (!rst_i && wr_o && rdy_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_out observed=0x%0h expected=none", wrdata_bo);
            end else begin
                chk("out_word", wrdata_bo, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        rdy_i = 1'b1;
        clr_wr();
        no_push();
        tick();
        tick();

        // Reset state
        chk("rst_cursize", 32'(cursize_o), 0);
        chk("rst_wr_o", 32'(wr_o), 0);
        chk("rst_wrdata", wrdata_bo, 0);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_wr_ready", 32'(wr_ready_o), 1);
        chk("rst_fifo_full", 32'(tag_fifo_full), 0);
        rst_i = 1'b0;

        // In-order single word
        push_tag(2'd0);
        tick();
        no_push();
        set_wr(0, 2'd0, 32'hA0);
        exp_q.push_back(32'hA0);
        tick();
        clr_wr();
        chk("io_cursize1", 32'(cursize_o), 1);
        chk("io_wr_o_early", 32'(wr_o), 0);
        tick();
        chk("io_wr_o", 32'(wr_o), 1);
        chk("io_wrdata", wrdata_bo, 32'hA0);
        chk("io_cursize0", 32'(cursize_o), 0);
        tick();
        chk("io_wr_o_idle", 32'(wr_o), 0);

        // Out-of-order: tags 2,1,0 required, words arrive tagged 0,1,2
        push_tag(2'd2);
        tick();
        push_tag(2'd1);
        tick();
        push_tag(2'd0);
        tick();
        no_push();
        set_wr(0, 2'd0, 32'hA0);
        set_wr(1, 2'd1, 32'hA1);
        set_wr(2, 2'd2, 32'hA2);
        exp_q.push_back(32'hA2);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA0);
        tick();
        clr_wr();
        chk("ooo_cursize3", 32'(cursize_o), 3);
        tick();
        chk("ooo_word0", wrdata_bo, 32'hA2);
        chk("ooo_cursize2", 32'(cursize_o), 2);
        tick();
        chk("ooo_word1", wrdata_bo, 32'hA1);
        tick();
        chk("ooo_word2", wrdata_bo, 32'hA0);
        chk("ooo_cursize0", 32'(cursize_o), 0);
        tick();
        chk("ooo_wr_o_idle", 32'(wr_o), 0);

        // Backpressure: 0x55 held for three stalled cycles, then 0x66 follows
        rdy_i = 1'b0;
        set_wr(0, 2'd1, 32'h55);
        set_wr(1, 2'd2, 32'h66);
        push_tag(2'd1);
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h66);
        tick();
        clr_wr();
        push_tag(2'd2);
        chk("bp_cursize2", 32'(cursize_o), 2);
        tick();
        no_push();
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_wr_o", 32'(wr_o), 1);
            chk("bp_hold_data", wrdata_bo, 32'h55);
            chk("bp_hold_cursize", 32'(cursize_o), 1);
            if (k < 2) tick();
        end
        rdy_i = 1'b1;
        tick();
        chk("bp_next_data", wrdata_bo, 32'h66);
        chk("bp_cursize0", 32'(cursize_o), 0);
        tick();
        chk("bp_wr_o_idle", 32'(wr_o), 0);

        // Overflow: fill with unrequested tag 3, then one write too many
        for (int p = 0; p < 4; p++) set_wr(p, 2'd3, 32'h100 + 32'(p));
        tick();
        chk("ov_cursize4", 32'(cursize_o), 4);
        chk("ov_ready4", 32'(wr_ready_o), 1);
        for (int p = 0; p < 4; p++) set_wr(p, 2'd3, 32'h104 + 32'(p));
        tick();
        clr_wr();
        chk("ov_cursize8", 32'(cursize_o), 8);
        chk("ov_ready8", 32'(wr_ready_o), 0);
        chk("ov_flag_pre", 32'(overflow_o), 0);
        set_wr(0, 2'd3, 32'h99);
        tick();
        clr_wr();
        chk("ov_cursize_held", 32'(cursize_o), 8);
        chk("ov_flag", 32'(overflow_o), 1);
        tick();
        tick();
        chk("ov_sticky", 32'(overflow_o), 1);
        chk("ov_no_out", 32'(wr_o), 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("ov_rst_flag", 32'(overflow_o), 0);
        chk("ov_rst_cursize", 32'(cursize_o), 0);

        // Duplicate tags resolved oldest first
        set_wr(0, 2'd1, 32'h11);
        set_wr(1, 2'd1, 32'h22);
        push_tag(2'd1);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        tick();
        clr_wr();
        push_tag(2'd1);
        tick();
        no_push();
        chk("dup_first", wrdata_bo, 32'h11);
        chk("dup_cursize1", 32'(cursize_o), 1);
        tick();
        chk("dup_second", wrdata_bo, 32'h22);
        tick();
        chk("dup_idle", 32'(wr_o), 0);

        // Tag FIFO full: ignored push, then push+pop while full
        for (int k = 0; k < 8; k++) begin
            push_tag(2'd0);
            tick();
        end
        chk("ff_full", 32'(tag_fifo_full), 1);
        push_tag(2'd1);
        tick();
        no_push();
        chk("ff_full_ign", 32'(tag_fifo_full), 1);
        for (int p = 0; p < 4; p++) set_wr(p, 2'd0, 32'hB0 + 32'(p));
        for (int k = 0; k < 8; k++) exp_q.push_back(32'hB0 + 32'(k));
        tick();
        chk("ff_cursize4", 32'(cursize_o), 4);
        for (int p = 0; p < 4; p++) set_wr(p, 2'd0, 32'hB4 + 32'(p));
        push_tag(2'd0);
        tick();
        clr_wr();
        no_push();
        chk("ff_first_out", wrdata_bo, 32'hB0);
        chk("ff_cursize7", 32'(cursize_o), 7);
        chk("ff_still_full", 32'(tag_fifo_full), 1);
        repeat (8) tick();
        chk("ff_drained", 32'(cursize_o), 0);
        chk("ff_idle", 32'(wr_o), 0);
        chk("ff_not_full", 32'(tag_fifo_full), 0);
        // The tag pushed while full is still queued and claims this word
        set_wr(0, 2'd0, 32'hC0);
        exp_q.push_back(32'hC0);
        tick();
        clr_wr();
        tick();
        chk("ff_late_tag", wrdata_bo, 32'hC0);
        tick();

        // Reset mid-operation, with a concurrent write and push
        for (int p = 0; p < 4; p++) set_wr(p, 2'd3, 32'hD0 + 32'(p));
        tick();
        clr_wr();
        set_wr(0, 2'd3, 32'hD4);
        push_tag(2'd2);
        tick();
        clr_wr();
        tick();
        tick();
        no_push();
        chk("mr_cursize5", 32'(cursize_o), 5);
        rst_i = 1'b1;
        set_wr(0, 2'd2, 32'hEE);
        push_tag(2'd2);
        tick();
        rst_i = 1'b0;
        clr_wr();
        no_push();
        chk("mr_cursize", 32'(cursize_o), 0);
        chk("mr_wr_o", 32'(wr_o), 0);
        chk("mr_wrdata", wrdata_bo, 0);
        chk("mr_overflow", 32'(overflow_o), 0);
        chk("mr_fifo_full", 32'(tag_fifo_full), 0);
        chk("mr_ready", 32'(wr_ready_o), 1);
        // Tags queued before reset must be gone: this word may not leave yet
        set_wr(0, 2'd2, 32'h77);
        tick();
        clr_wr();
        repeat (3) tick();
        chk("mr_no_stale", 32'(wr_o), 0);
        chk("mr_cursize1", 32'(cursize_o), 1);
        push_tag(2'd2);
        exp_q.push_back(32'h77);
        tick();
        no_push();
        tick();
        chk("mr_out", wrdata_bo, 32'h77);
        tick();
        chk("mr_idle", 32'(wr_o), 0);
        chk("mr_cursize0", 32'(cursize_o), 0);

        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
